// File: rtl/mem_req_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single SRAM-like memory bus.
// Keeps an in-order owner FIFO so each bus response is routed back to its requester.
module mem_req_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_OUTST    = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        inst_req,
   input  logic [ADDR_W-1:0]           inst_addr,
   output logic                        inst_addr_ok,
   output logic                        inst_data_ok,
   output logic [DATA_W-1:0]           inst_rdata,
   input  logic                        data_req,
   input  logic                        data_wr,
   input  logic [1:0]                  data_size,
   input  logic [ADDR_W-1:0]           data_addr,
   input  logic [DATA_W-1:0]           data_wdata,
   output logic                        data_addr_ok,
   output logic                        data_data_ok,
   output logic [DATA_W-1:0]           data_rdata,
   output logic                        bus_req,
   output logic                        bus_wr,
   output logic [1:0]                  bus_size,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic [DATA_W-1:0]           bus_wdata,
   input  logic                        bus_addr_ok,
   input  logic                        bus_data_ok,
   input  logic [DATA_W-1:0]           bus_rdata,
   output logic [$clog2(MAX_OUTST):0]  outst_cnt,
   output logic                        resp_err
);

   localparam int PTR_W = $clog2(MAX_OUTST);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTST);
   localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

   logic [MAX_OUTST-1:0] owner_q;   // 1 = data port, 0 = inst port
   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [STV_W-1:0]     starve_cnt;
   logic                 full;
   logic                 empty;
   logic                 sel_data;
   logic                 sel_inst;
   logic                 grant;
   logic                 pop;
   logic                 head_owner;

   // Handshake: a port request is held stable until its addr_ok pulse; that pulse is the
   // bus grant itself (bus_req && bus_addr_ok). Responses come back in issue order, one
   // data_ok per bus_data_ok, never in the same cycle as the matching addr_ok.
   always_comb begin
      full       = (outst_cnt == FULL_CNT);
      empty      = (outst_cnt == '0);
      sel_data   = data_req && !(inst_req && (starve_cnt == STARVE_MAX));
      sel_inst   = inst_req && !sel_data;
      // Full uses the registered count, so a same-cycle pop cannot re-open the bus.
      bus_req    = !reset && (inst_req || data_req) && !full;
      grant      = bus_req && bus_addr_ok;
      pop        = !reset && bus_data_ok && !empty;
      head_owner = owner_q[head];

      bus_wr    = 1'b0;
      bus_size  = 2'b10;
      bus_addr  = inst_addr;
      bus_wdata = '0;
      if (sel_data) begin
         bus_wr    = data_wr;
         bus_size  = data_size;
         bus_addr  = data_addr;
         bus_wdata = data_wdata;
      end

      inst_addr_ok = grant && sel_inst;
      data_addr_ok = grant && sel_data;
      inst_data_ok = pop && !head_owner;
      data_data_ok = pop && head_owner;
      inst_rdata   = bus_rdata;
      data_rdata   = bus_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         outst_cnt  <= '0;
         starve_cnt <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (grant) tail <= tail + PTR_W'(1);
         if (pop)   head <= head + PTR_W'(1);
         case ({grant, pop})
            2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
            2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
            default: outst_cnt <= outst_cnt;
         endcase
         if (bus_data_ok && empty) resp_err <= 1'b1;
         // Counts consecutive data wins while inst waits; at the limit inst takes the bus.
         if (!inst_req || (grant && sel_inst)) begin
            starve_cnt <= '0;
         end else if (grant && sel_data && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + STV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant) owner_q[tail] <= sel_data;
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: a reference model of the arbitration rules plus a
// bus responder; responses are scored by a separate monitor against an expected queue.
module tb_mem_req_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int MAX_OUTST    = 4;
   localparam int STARVE_LIMIT = 4;

   logic                        clk;
   logic                        reset;
   logic                        inst_req;
   logic [ADDR_W-1:0]           inst_addr;
   logic                        inst_addr_ok;
   logic                        inst_data_ok;
   logic [DATA_W-1:0]           inst_rdata;
   logic                        data_req;
   logic                        data_wr;
   logic [1:0]                  data_size;
   logic [ADDR_W-1:0]           data_addr;
   logic [DATA_W-1:0]           data_wdata;
   logic                        data_addr_ok;
   logic                        data_data_ok;
   logic [DATA_W-1:0]           data_rdata;
   logic                        bus_req;
   logic                        bus_wr;
   logic [1:0]                  bus_size;
   logic [ADDR_W-1:0]           bus_addr;
   logic [DATA_W-1:0]           bus_wdata;
   logic                        bus_addr_ok;
   logic                        bus_data_ok;
   logic [DATA_W-1:0]           bus_rdata;
   logic [$clog2(MAX_OUTST):0]  outst_cnt;
   logic                        resp_err;

   mem_req_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .outst_cnt(outst_cnt), .resp_err(resp_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      int                ready;
   } bus_ent_t;

   // scoreboard: {owner (1 = data), rdata}
   logic [DATA_W:0] exp_q[$];
   bus_ent_t        bus_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int m_cnt = 0;
   int m_starve = 0;
   bit m_err = 0;
   bit inst_pend = 0;
   bit data_pend = 0;
   int p_inst, p_data, p_aok, p_resp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // driver + reference model, one call per clock cycle
   task automatic step(input bit rst, input bit spur);
      bit e_req, e_sel_data, e_grant, e_pop;
      logic [DATA_W-1:0] rd;
      bus_ent_t ent;
      @(negedge clk);
      reset = rst;
      if (!inst_pend && ($urandom_range(0, 99) < p_inst)) begin
         inst_pend = 1;
         inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_pend && ($urandom_range(0, 99) < p_data)) begin
         data_pend  = 1;
         data_wr    = 1'($urandom_range(0, 1));
         data_size  = 2'($urandom_range(0, 2));
         data_addr  = $urandom;
         data_wdata = $urandom;
      end
      inst_req    = inst_pend;
      data_req    = data_pend;
      bus_addr_ok = ($urandom_range(0, 99) < p_aok);
      if (spur && bus_q.size() == 0) begin
         bus_data_ok = 1'b1;
         bus_rdata   = $urandom;
      end else if (bus_q.size() != 0 && bus_q[0].ready <= cyc &&
                   $urandom_range(0, 99) < p_resp) begin
         bus_data_ok = 1'b1;
         bus_rdata   = bus_q[0].rdata;
      end else begin
         bus_data_ok = 1'b0;
         bus_rdata   = $urandom;
      end
      #1;
      e_req      = !rst && (inst_req || data_req) && (m_cnt != MAX_OUTST);
      e_sel_data = data_req && !(inst_req && m_starve == STARVE_LIMIT);
      e_grant    = e_req && bus_addr_ok;
      e_pop      = !rst && bus_data_ok && (m_cnt != 0);
      check("bus_req", 64'(bus_req), 64'(e_req));
      check("inst_addr_ok", 64'(inst_addr_ok), 64'(e_grant && !e_sel_data));
      check("data_addr_ok", 64'(data_addr_ok), 64'(e_grant && e_sel_data));
      check("any_data_ok", 64'(inst_data_ok || data_data_ok), 64'(e_pop));
      check("outst_cnt", 64'(outst_cnt), 64'(m_cnt));
      check("resp_err", 64'(resp_err), 64'(m_err));
      if (e_req) begin
         check("bus_wr", 64'(bus_wr), e_sel_data ? 64'(data_wr) : 64'(0));
         check("bus_size", 64'(bus_size), e_sel_data ? 64'(data_size) : 64'(2));
         check("bus_addr", 64'(bus_addr), e_sel_data ? 64'(data_addr) : 64'(inst_addr));
         check("bus_wdata", 64'(bus_wdata), e_sel_data ? 64'(data_wdata) : 64'(0));
      end
      if (rst) begin
         bus_q.delete();
         exp_q.delete();
         m_cnt    = 0;
         m_starve = 0;
         m_err    = 0;
      end else begin
         if (e_pop) ent = bus_q.pop_front();
         if (bus_data_ok && m_cnt == 0) m_err = 1;
         if (e_grant) begin
            rd        = $urandom;
            ent.rdata = rd;
            ent.ready = cyc + 1 + $urandom_range(0, 3);
            bus_q.push_back(ent);
            exp_q.push_back({e_sel_data, rd});
            if (e_sel_data) data_pend = 0;
            else            inst_pend = 0;
         end
         if (!inst_req || (e_grant && !e_sel_data)) m_starve = 0;
         else if (e_grant && e_sel_data && m_starve < STARVE_LIMIT) m_starve++;
         m_cnt = m_cnt + int'(e_grant) - int'(e_pop);
      end
      cyc++;
   endtask

   task automatic set_mix(input int pi, input int pd, input int pa, input int pr);
      p_inst = pi;
      p_data = pd;
      p_aok  = pa;
      p_resp = pr;
   endtask

   task automatic drain();
      set_mix(0, 0, 100, 100);
      for (int i = 0; i < 200; i++) begin
         if (m_cnt == 0 && !inst_pend && !data_pend) break;
         step(0, 0);
      end
      check("drained", 64'(m_cnt), 64'(0));
   endtask

   // monitor: pops the expected queue whenever the DUT presents a response
   always @(negedge clk) begin
      logic [DATA_W:0] e;
      #2;
      if (inst_data_ok || data_data_ok) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected cyc=%0d inst_data_ok=%0b data_data_ok=%0b expected none",
                     cyc, inst_data_ok, data_data_ok);
         end else begin
            e = exp_q.pop_front();
            check("resp_owner", 64'({data_data_ok, inst_data_ok}), e[DATA_W] ? 64'(2) : 64'(1));
            check("resp_rdata", e[DATA_W] ? 64'(data_rdata) : 64'(inst_rdata),
                  64'(e[DATA_W-1:0]));
         end
      end
   end

   initial begin
      reset       = 1'b1;
      inst_req    = 1'b0;
      inst_addr   = '0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_size   = 2'b00;
      data_addr   = '0;
      data_wdata  = '0;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;

      // reset with both ports requesting
      set_mix(100, 100, 100, 100);
      repeat (3) step(1, 0);
      inst_pend = 0;
      data_pend = 0;

      set_mix(40, 40, 70, 50);
      repeat (800) step(0, 0);
      // both ports saturated: exercises the starvation limit
      set_mix(100, 100, 100, 90);
      repeat (400) step(0, 0);
      // slow bus: exercises the full condition
      set_mix(60, 60, 90, 10);
      repeat (400) step(0, 0);
      drain();

      // stray response with nothing outstanding
      set_mix(0, 0, 100, 0);
      step(0, 1);
      repeat (5) step(0, 0);

      // reset while three requests are in flight
      set_mix(100, 100, 100, 0);
      for (int i = 0; i < 50; i++) begin
         if (m_cnt >= 3) break;
         step(0, 0);
      end
      check("pre_reset_outst", 64'(m_cnt), 64'(3));
      set_mix(100, 100, 100, 100);
      repeat (2) step(1, 0);
      inst_pend = 0;
      data_pend = 0;
      set_mix(0, 0, 100, 100);
      repeat (3) step(0, 0);

      set_mix(50, 50, 80, 60);
      repeat (300) step(0, 0);
      drain();
      repeat (3) step(0, 0);
      check("exp_q_empty", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
